// File: rtl/axis_tag_pkg.sv
// axis_tag_pkg: shared limits, counter type and round-robin pick helper
// for the tag stream fan-in blocks.
package axis_tag_pkg;

  localparam int MAX_FANIN = 16;

  typedef logic [31:0] stat_cnt_t;

  // Valid bits above FANIN are always zero, so a scan modulo MAX_FANIN visits
  // the live inputs in the same order as a scan modulo FANIN would.
  function automatic logic [3:0] rr_pick(input logic [MAX_FANIN-1:0] valid,
                                         input logic [3:0]           ptr);
    logic [3:0] idx;
    rr_pick = ptr;
    for (int k = MAX_FANIN - 1; k >= 0; k--) begin
      idx = ptr + 4'(k);
      if (valid[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/axis_tag_combine_if.sv
// axis_tag_interface: one time-tag word stream (WORD_WIDTH lanes) with a
// conservative lowest_time_bound side channel.
interface axis_tag_interface #(
  parameter int WORD_WIDTH    = 4,
  parameter int TIME_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 6
);
  logic                                     clk;
  logic                                     rst;
  logic                                     tvalid;
  logic                                     tready;
  logic [WORD_WIDTH-1:0][TIME_WIDTH-1:0]    tagtime;
  logic [WORD_WIDTH-1:0][CHANNEL_WIDTH-1:0] channel;
  logic [WORD_WIDTH-1:0]                    tkeep;
  logic [TIME_WIDTH-1:0]                    lowest_time_bound;

  modport master (
    output clk, rst, tvalid, tagtime, channel, tkeep, lowest_time_bound,
    input  tready
  );

  modport slave (
    input  clk, rst, tvalid, tagtime, channel, tkeep, lowest_time_bound,
    output tready
  );
endinterface

// File: rtl/axis_tag_rr_arbiter.sv
// axis_tag_rr_arbiter: combinational round-robin grant plus the rotating
// pointer, which advances past the granted input whenever a word is accepted.
module axis_tag_rr_arbiter
  import axis_tag_pkg::*;
#(
  parameter  int FANIN = 2,
  localparam int RR_W  = (FANIN > 1) ? $clog2(FANIN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [FANIN-1:0] valid,
  input  logic             advance,
  output logic [RR_W-1:0]  grant,
  output logic             any_valid
);

  logic [RR_W-1:0] rr;

  assign any_valid = |valid;
  assign grant     = RR_W'(rr_pick(MAX_FANIN'(valid), 4'(rr)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= '0;
    end else if (advance) begin
      rr <= (grant == RR_W'(FANIN - 1)) ? '0 : grant + RR_W'(1);
    end
  end

endmodule

// File: rtl/axis_tag_combine.sv
// axis_tag_combine: round-robin word merge of FANIN tag streams into one
// registered output; optional per-input counters with AXIS_TAG_COMBINE_STATS_EN.
module axis_tag_combine
  import axis_tag_pkg::*;
#(
  parameter  int FANIN         = 2,
  parameter  int WORD_WIDTH    = 4,
  parameter  int TIME_WIDTH    = 64,
  parameter  int CHANNEL_WIDTH = 6,
  localparam int RR_W          = (FANIN > 1) ? $clog2(FANIN) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  axis_tag_interface.slave  s_axis [FANIN],
  axis_tag_interface.master m_axis
`ifdef AXIS_TAG_COMBINE_STATS_EN
  ,
  output stat_cnt_t         word_count [FANIN]
`endif
);

  if (FANIN < 2 || FANIN > MAX_FANIN) begin : g_bad_fanin
    $error("axis_tag_combine: FANIN must be within 2..16");
  end
  if ($bits(m_axis.tkeep) != WORD_WIDTH || $bits(m_axis.lowest_time_bound) != TIME_WIDTH
      || $bits(m_axis.channel) != WORD_WIDTH * CHANNEL_WIDTH) begin : g_bad_m_width
    $error("axis_tag_combine: m_axis widths disagree with block parameters");
  end

  logic [FANIN-1:0]                         in_valid;
  logic [FANIN-1:0]                         rdy;
  logic [WORD_WIDTH-1:0][TIME_WIDTH-1:0]    in_time  [FANIN];
  logic [WORD_WIDTH-1:0][CHANNEL_WIDTH-1:0] in_chan  [FANIN];
  logic [WORD_WIDTH-1:0]                    in_keep  [FANIN];
  logic [TIME_WIDTH-1:0]                    in_bound [FANIN];

  logic [RR_W-1:0]                          grant;
  logic                                     any_valid;
  logic                                     load;
  logic                                     accept;
  logic [WORD_WIDTH-1:0][TIME_WIDTH-1:0]    sel_time;
  logic [WORD_WIDTH-1:0][CHANNEL_WIDTH-1:0] sel_chan;
  logic [WORD_WIDTH-1:0]                    sel_keep;
  logic [TIME_WIDTH-1:0]                    cand;

  logic                                     out_valid;
  logic [WORD_WIDTH-1:0][TIME_WIDTH-1:0]    out_time;
  logic [WORD_WIDTH-1:0][CHANNEL_WIDTH-1:0] out_chan;
  logic [WORD_WIDTH-1:0]                    out_keep;
  logic [TIME_WIDTH-1:0]                    out_bound;

  for (genvar i = 0; i < FANIN; i++) begin : g_in
    if ($bits(s_axis[i].tkeep) != WORD_WIDTH || $bits(s_axis[i].lowest_time_bound) != TIME_WIDTH
        || $bits(s_axis[i].channel) != WORD_WIDTH * CHANNEL_WIDTH) begin : g_bad_s_width
      $error("axis_tag_combine: s_axis widths disagree with block parameters");
    end
    assign in_valid[i]      = s_axis[i].tvalid;
    assign in_time[i]       = s_axis[i].tagtime;
    assign in_chan[i]       = s_axis[i].channel;
    assign in_keep[i]       = s_axis[i].tkeep;
    assign in_bound[i]      = s_axis[i].lowest_time_bound;
    assign rdy[i]           = accept && (grant == RR_W'(i));
    assign s_axis[i].tready = rdy[i];
  end

  axis_tag_rr_arbiter #(.FANIN(FANIN)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (in_valid),
    .advance   (accept),
    .grant     (grant),
    .any_valid (any_valid)
  );

  // rst_n gate keeps every input stalled while the block is held in reset.
  assign load   = !out_valid || m_axis.tready;
  assign accept = rst_n && load && any_valid;

  always_comb begin
    sel_time = in_time[grant];
    sel_chan = in_chan[grant];
    sel_keep = in_keep[grant];
    cand     = in_bound[0];
    for (int i = 1; i < FANIN; i++) begin
      if (in_bound[i] < cand) cand = in_bound[i];
    end
  end

  // Empty words are consumed and dropped without disturbing the held data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_time  <= '0;
      out_chan  <= '0;
      out_keep  <= '0;
      out_bound <= '0;
    end else begin
      if (load) out_valid <= accept && (sel_keep != '0);
      if (accept && (sel_keep != '0)) begin
        out_time <= sel_time;
        out_chan <= sel_chan;
        out_keep <= sel_keep;
      end
      if (cand > out_bound) out_bound <= cand;
    end
  end

  assign m_axis.clk               = clk;
  assign m_axis.rst               = !rst_n;
  assign m_axis.tvalid            = out_valid;
  assign m_axis.tagtime           = out_time;
  assign m_axis.channel           = out_chan;
  assign m_axis.tkeep             = out_keep;
  assign m_axis.lowest_time_bound = out_bound;

`ifdef AXIS_TAG_COMBINE_STATS_EN
  stat_cnt_t cnt_q [FANIN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FANIN; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < FANIN; i++) begin
        if (rdy[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + stat_cnt_t'(1);
      end
    end
  end

  assign word_count = cnt_q;
`endif

endmodule

// File: tb/tb_axis_tag_combine.sv
// tb_axis_tag_combine: randomized and directed traffic against a queue-based
// reference of the round-robin merge, with a separate output monitor.
module tb_axis_tag_combine;
  import axis_tag_pkg::*;

  localparam int FANIN = 2;
  localparam int WW    = 4;
  localparam int TW    = 64;
  localparam int CW    = 6;

  typedef struct packed {
    logic [WW-1:0][TW-1:0] t;
    logic [WW-1:0][CW-1:0] c;
    logic [WW-1:0]         k;
  } word_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_tag_interface #(.WORD_WIDTH(WW), .TIME_WIDTH(TW), .CHANNEL_WIDTH(CW)) s_axis [FANIN] ();
  axis_tag_interface #(.WORD_WIDTH(WW), .TIME_WIDTH(TW), .CHANNEL_WIDTH(CW)) m_axis ();

  logic [FANIN-1:0] drv_valid = '0;
  logic [FANIN-1:0] s_rdy;
  word_t            drv_word  [FANIN];
  logic [TW-1:0]    drv_bound [FANIN];
  logic             m_tready = 1'b0;

  for (genvar g = 0; g < FANIN; g++) begin : g_src
    assign s_axis[g].clk               = clk;
    assign s_axis[g].rst               = !rst_n;
    assign s_axis[g].tvalid            = drv_valid[g];
    assign s_axis[g].tagtime           = drv_word[g].t;
    assign s_axis[g].channel           = drv_word[g].c;
    assign s_axis[g].tkeep             = drv_word[g].k;
    assign s_axis[g].lowest_time_bound = drv_bound[g];
    assign s_rdy[g]                    = s_axis[g].tready;
  end
  assign m_axis.tready = m_tready;

`ifdef AXIS_TAG_COMBINE_STATS_EN
  stat_cnt_t word_count [FANIN];
`endif

  axis_tag_combine #(
    .FANIN(FANIN), .WORD_WIDTH(WW), .TIME_WIDTH(TW), .CHANNEL_WIDTH(CW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_axis (s_axis),
    .m_axis (m_axis)
`ifdef AXIS_TAG_COMBINE_STATS_EN
    ,
    .word_count (word_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // reference state
  word_t          pend [FANIN][$];
  word_t          exp_q[$];
  int             rr_m;
  bit             mv;
  logic [TW-1:0]  exp_bound;
  int unsigned    cnt_m [FANIN];
  int             out_words;
  bit [FANIN-1:0] took;

  int  p_valid [FANIN];
  int  p_mready;
  bit  rand_bounds;

  task automatic check(input string name, input logic [299:0] act, input logic [299:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s bound expired", name);
  endtask

  function automatic word_t rand_word(input bit allow_empty);
    word_t w;
    for (int l = 0; l < WW; l++) begin
      w.t[l] = {$urandom, $urandom};
      w.c[l] = CW'($urandom);
    end
    w.k = WW'($urandom);
    if (!allow_empty && w.k == '0) w.k = 4'b1000;
    return w;
  endfunction

  // Reference: a one-word output slot fed by a rotating preference order.
  task automatic model_step();
    logic [FANIN-1:0] exp_rdy;
    logic [TW-1:0]    lo;
    int               g;
    bit               ld;
    exp_rdy = '0;
    for (int i = 0; i < FANIN; i++) took[i] = drv_valid[i] && s_rdy[i];
    if (!rst_n) begin
      check("s_tready_in_reset", 300'(s_rdy), 300'(0));
      rr_m = 0;
      mv = 0;
      exp_q.delete();
      exp_bound = '0;
      for (int i = 0; i < FANIN; i++) cnt_m[i] = 0;
      return;
    end
    ld = !mv || m_tready;
    g = -1;
    for (int k = 0; k < FANIN; k++) begin
      if (g < 0 && drv_valid[(rr_m + k) % FANIN]) g = (rr_m + k) % FANIN;
    end
    if (ld && g >= 0) exp_rdy[g] = 1'b1;
    check("s_tready", 300'(s_rdy), 300'(exp_rdy));
    if (ld) begin
      mv = 0;
      if (g >= 0) begin
        rr_m = (g + 1) % FANIN;
        cnt_m[g]++;
        if (drv_word[g].k != '0) begin
          exp_q.push_back(drv_word[g]);
          mv = 1;
        end
      end
    end
    lo = drv_bound[0];
    for (int i = 1; i < FANIN; i++) if (drv_bound[i] < lo) lo = drv_bound[i];
    if (lo > exp_bound) exp_bound = lo;
  endtask

  task automatic present();
    for (int i = 0; i < FANIN; i++) begin
      if (!drv_valid[i] && pend[i].size() > 0 && int'($urandom_range(99)) < p_valid[i]) begin
        drv_word[i]  = pend[i][0];
        drv_valid[i] = 1'b1;
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < FANIN; i++) begin
      if (took[i]) begin
        drv_valid[i] = 1'b0;
        pend[i].delete(0);
      end
    end
    present();
    m_tready = int'($urandom_range(99)) < p_mready;
    if (rand_bounds) begin
      for (int i = 0; i < FANIN; i++) drv_bound[i] = {32'h0, $urandom};
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input string name, input int max, output int n);
    n = 0;
    while ((pend[0].size() + pend[1].size() + exp_q.size() != 0 || drv_valid != '0) && n < max) begin
      cycle();
      n++;
    end
    if (n >= max) fail_now(name);
  endtask

  // Monitor: compares every presented output word against the reference queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("m_rst", 300'(m_axis.rst), 300'(0));
        check("m_tvalid", 300'(m_axis.tvalid), 300'(exp_q.size() != 0));
        if (m_axis.tvalid && exp_q.size() != 0) begin
          check("m_word", 300'({m_axis.tagtime, m_axis.channel, m_axis.tkeep}), 300'(exp_q[0]));
          if (m_tready) begin
            exp_q.pop_front();
            out_words++;
          end
        end
        check("m_bound", 300'(m_axis.lowest_time_bound), 300'(exp_bound));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks + 1, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w0;
    word_t w;
    for (int i = 0; i < FANIN; i++) begin
      drv_word[i]  = '0;
      drv_bound[i] = '0;
      p_valid[i]   = 100;
    end
    p_mready    = 100;
    rand_bounds = 0;
    out_words   = 0;
    rr_m = 0;
    mv = 0;
    exp_bound = '0;

    // both sources queue four words and offer the first while still in reset
    for (int j = 0; j < 4; j++) begin
      pend[0].push_back(rand_word(0));
      pend[1].push_back(rand_word(0));
    end
    present();
    repeat (3) cycle();
    check("rst_m_tvalid", 300'(m_axis.tvalid), 300'(0));
    check("rst_m_tkeep", 300'(m_axis.tkeep), 300'(0));
    check("rst_m_rst", 300'(m_axis.rst), 300'(1));
    check("rst_m_bound", 300'(m_axis.lowest_time_bound), 300'(0));
    m_tready = 1'b1;
    rst_n = 1'b1;

    w0 = out_words;
    drain("interleave_drain", 50, n);
    check("interleave_cycles", 300'(n), 300'(9));
    check("interleave_words", 300'(out_words - w0), 300'(8));

    // single active source streams back to back
    for (int j = 0; j < 5; j++) pend[1].push_back(rand_word(0));
    present();
    w0 = out_words;
    drain("single_drain", 50, n);
    check("single_cycles", 300'(n), 300'(6));
    check("single_words", 300'(out_words - w0), 300'(5));

    // output stall with both inputs waiting
    for (int j = 0; j < 3; j++) begin
      pend[0].push_back(rand_word(0));
      pend[1].push_back(rand_word(0));
    end
    present();
    repeat (2) cycle();
    p_mready = 0;
    m_tready = 1'b0;
    repeat (3) cycle();
    check("stall_held_valid", 300'(m_axis.tvalid), 300'(1));
    p_mready = 100;
    m_tready = 1'b1;
    drain("stall_drain", 50, n);

    // empty word is consumed but never presented
    w0 = out_words;
    n  = int'(cnt_m[0]);
    w = rand_word(0);
    w.k = 4'b0000;
    pend[0].push_back(w);
    w = rand_word(0);
    w.k = 4'b0101;
    pend[0].push_back(w);
    present();
    drain("keep_drain", 50, n);
    check("keep_words", 300'(out_words - w0), 300'(1));
`ifdef AXIS_TAG_COMBINE_STATS_EN
    check("keep_word_count0", 300'(word_count[0]), 300'(cnt_m[0]));
    check("word_count1", 300'(word_count[1]), 300'(cnt_m[1]));
`endif

    // bound merge
    drv_bound[0] = 64'd100;
    drv_bound[1] = 64'd50;
    cycle();
    check("bound_min", 300'(m_axis.lowest_time_bound), 300'(64'd50));
    drv_bound[0] = 64'd30;
    drv_bound[1] = 64'd200;
    repeat (2) cycle();
    check("bound_hold", 300'(m_axis.lowest_time_bound), 300'(64'd50));
    drv_bound[0] = 64'd300;
    drv_bound[1] = 64'd300;
    cycle();
    check("bound_rise", 300'(m_axis.lowest_time_bound), 300'(64'd300));

    // randomized traffic, back-pressure and bounds
    rand_bounds = 1;
    p_mready    = 70;
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) begin
        for (int i = 0; i < FANIN; i++) p_valid[i] = int'($urandom_range(100, 20));
        p_mready = int'($urandom_range(100, 30));
      end
      for (int i = 0; i < FANIN; i++) begin
        if (pend[i].size() < 3) pend[i].push_back(rand_word(1));
      end
      cycle();
    end
    rand_bounds = 0;
    for (int i = 0; i < FANIN; i++) p_valid[i] = 100;
    p_mready = 100;
    drain("random_drain", 200, n);
`ifdef AXIS_TAG_COMBINE_STATS_EN
    check("random_word_count0", 300'(word_count[0]), 300'(cnt_m[0]));
    check("random_word_count1", 300'(word_count[1]), 300'(cnt_m[1]));
`endif

    // reset while a word sits in the stalled output register
    for (int j = 0; j < 3; j++) begin
      pend[0].push_back(rand_word(0));
      pend[1].push_back(rand_word(0));
    end
    present();
    p_mready = 0;
    m_tready = 1'b0;
    repeat (2) cycle();
    check("pre_reset_valid", 300'(m_axis.tvalid), 300'(1));
    rst_n = 1'b0;
    #1;
    check("mid_reset_tvalid", 300'(m_axis.tvalid), 300'(0));
    check("mid_reset_tready", 300'(s_rdy), 300'(0));
    check("mid_reset_bound", 300'(m_axis.lowest_time_bound), 300'(0));
    repeat (2) cycle();
    rst_n = 1'b1;
    p_mready = 100;
    m_tready = 1'b1;
    drain("post_reset_drain", 50, n);
`ifdef AXIS_TAG_COMBINE_STATS_EN
    check("post_reset_count0", 300'(word_count[0]), 300'(cnt_m[0]));
`endif
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
